// File: rtl/rxcorr_pkg.sv
// Shared definitions for the receive access-code correlator.
// Holds the FSM state encoding, the sync/trailer lengths and the two
// expected trailer patterns.
package rxcorr_pkg;

  localparam int SYNCLEN  = 64;
  localparam int TRAILLEN = 4;

  // Trailer patterns as they appear in the trailer shift register, which
  // fills LSB-first like the sync register (bit 0 = first bit received).
  // Receive order 1,0,1,0 when syncword[63] = 0.
  localparam logic [3:0] TRAILER_SW0 = 4'b0101;
  // Receive order 0,1,0,1 when syncword[63] = 1.
  localparam logic [3:0] TRAILER_SW1 = 4'b1010;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEARCH  = 3'd1,
    ST_TRAILER = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_WAITOFF = 3'd4
  } corr_state_e;

endpackage

// File: rtl/rxaccesscorr_popcount64.sv
// popcount64: combinational population count of a 64-bit word.
// Ports:
//   data_i  [63:0] word to count
//   count_o [6:0]  number of ones in data_i (0..64)
// Built as a balanced adder tree so the depth is six small adders.
module popcount64 (
  input  logic [63:0] data_i,
  output logic [6:0]  count_o
);

  logic [1:0] l1 [32];
  logic [2:0] l2 [16];
  logic [3:0] l3 [8];
  logic [4:0] l4 [4];
  logic [5:0] l5 [2];

  genvar i;

  for (i = 0; i < 32; i++) begin : g_l1
    assign l1[i] = {1'b0, data_i[2*i]} + {1'b0, data_i[2*i+1]};
  end

  for (i = 0; i < 16; i++) begin : g_l2
    assign l2[i] = {1'b0, l1[2*i]} + {1'b0, l1[2*i+1]};
  end

  for (i = 0; i < 8; i++) begin : g_l3
    assign l3[i] = {1'b0, l2[2*i]} + {1'b0, l2[2*i+1]};
  end

  for (i = 0; i < 4; i++) begin : g_l4
    assign l4[i] = {1'b0, l3[2*i]} + {1'b0, l3[2*i+1]};
  end

  for (i = 0; i < 2; i++) begin : g_l5
    assign l5[i] = {1'b0, l4[2*i]} + {1'b0, l4[2*i+1]};
  end

  assign count_o = {1'b0, l5[0]} + {1'b0, l5[1]};

endmodule

// File: rtl/rxaccesscorr.sv
// rxaccesscorr: receive access-code correlator.
// Slides a 64-bit window of received bits against the programmed sync word
// and pulses rx_trailer_st_p when the Hamming match reaches threshold; then
// checks the 4-bit trailer and reports lock, or times out after the window.
// Ports:
//   clk_6M          system clock
//   rstz            asynchronous reset, active-high
//   p_1us           one-cycle bit strobe, rxbit valid in that cycle
//   rxbit           demodulated bit, LSB-first
//   corr_en         search enable (level)
//   regi_syncword   expected sync word, bit 0 received first
//   regi_corrthr    match threshold (values above 64 never match)
//   regi_searchwin  search window length in strobes
//   rx_trailer_st_p pulse one cycle after the strobe that completed a match
//   sync_lock       level, trailer received after a match
//   trailer_err     level, received trailer differed from expected
//   corr_timeout_p  pulse one cycle after the strobe that ended the window
//   corr_peak       best match count since the search started
//   dbg_state       current FSM state
// Handshake: p_1us is a qualifier, not a valid/ready pair; a bit is consumed
// in every cycle p_1us is high while searching or receiving the trailer,
// and there is no back-pressure.
module rxaccesscorr #(
  parameter int SYNCLEN  = 64,
  parameter int TRAILLEN = 4,
  parameter int WINW     = 12
) (
  input  logic               clk_6M,
  input  logic               rstz,
  input  logic               p_1us,
  input  logic               rxbit,
  input  logic               corr_en,
  input  logic [SYNCLEN-1:0] regi_syncword,
  input  logic [6:0]         regi_corrthr,
  input  logic [WINW-1:0]    regi_searchwin,
  output logic               rx_trailer_st_p,
  output logic               sync_lock,
  output logic               trailer_err,
  output logic               corr_timeout_p,
  output logic [6:0]         corr_peak,
  output logic [2:0]         dbg_state
);

  import rxcorr_pkg::*;

  corr_state_e        state_q, state_d;
  logic [SYNCLEN-1:0] sreg_q, sreg_d, sreg_shift;
  logic [6:0]         fill_q, fill_d, fill_inc;
  logic [WINW-1:0]    wincnt_q, wincnt_d;
  logic [WINW:0]      wincnt_inc;
  logic [1:0]         tcnt_q, tcnt_d;
  logic [3:0]         trail_q, trail_d, trail_shift, trail_exp;
  logic [6:0]         peak_q, peak_d;
  logic               st_pulse_q, st_pulse_d;
  logic               to_pulse_q, to_pulse_d;
  logic               terr_q, terr_d;
  logic [6:0]         ones, mcnt;
  logic               match_ok, win_done;

  // Correlate against the window as it will be after this strobe, so a
  // match is flagged on the same strobe that delivers the last sync bit.
  assign sreg_shift = {rxbit, sreg_q[SYNCLEN-1:1]};

  popcount64 u_popcount (
    .data_i  (sreg_shift ^ regi_syncword),
    .count_o (ones)
  );

  assign mcnt     = 7'd64 - ones;
  assign fill_inc = (fill_q == 7'(SYNCLEN)) ? fill_q : fill_q + 7'd1;
  // Only a completely filled window may match.
  assign match_ok = (fill_inc == 7'(SYNCLEN)) && (mcnt >= regi_corrthr);

  // One bit wider than the counter so the compare never wraps; a window of
  // 0 expires on the very first strobe.
  assign wincnt_inc = {1'b0, wincnt_q} + {{WINW{1'b0}}, 1'b1};
  assign win_done   = wincnt_inc >= {1'b0, regi_searchwin};

  assign trail_shift = {rxbit, trail_q[3:1]};
  assign trail_exp   = regi_syncword[SYNCLEN-1] ? TRAILER_SW1 : TRAILER_SW0;

  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    fill_d     = fill_q;
    wincnt_d   = wincnt_q;
    tcnt_d     = tcnt_q;
    trail_d    = trail_q;
    peak_d     = peak_q;
    terr_d     = terr_q;
    st_pulse_d = 1'b0;
    to_pulse_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (corr_en) begin
          state_d  = ST_SEARCH;
          sreg_d   = '0;
          fill_d   = '0;
          wincnt_d = '0;
          peak_d   = '0;
          terr_d   = 1'b0;
        end
      end

      ST_SEARCH: begin
        if (!corr_en) begin
          state_d = ST_IDLE;
        end else if (p_1us) begin
          sreg_d   = sreg_shift;
          fill_d   = fill_inc;
          wincnt_d = wincnt_inc[WINW-1:0];
          peak_d   = (mcnt > peak_q) ? mcnt : peak_q;
          // Match wins over timeout on the same strobe.
          if (match_ok) begin
            st_pulse_d = 1'b1;
            tcnt_d     = '0;
            trail_d    = '0;
            state_d    = ST_TRAILER;
          end else if (win_done) begin
            to_pulse_d = 1'b1;
            state_d    = ST_WAITOFF;
          end
        end
      end

      ST_TRAILER: begin
        if (!corr_en) begin
          state_d = ST_IDLE;
        end else if (p_1us) begin
          trail_d = trail_shift;
          if (tcnt_q == 2'(TRAILLEN - 1)) begin
            terr_d  = (trail_shift != trail_exp);
            state_d = ST_LOCKED;
          end else begin
            tcnt_d = tcnt_q + 2'd1;
          end
        end
      end

      ST_LOCKED: begin
        if (!corr_en) state_d = ST_IDLE;
      end

      ST_WAITOFF: begin
        if (!corr_en) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_6M or posedge rstz) begin
    if (rstz) begin
      state_q    <= ST_IDLE;
      sreg_q     <= '0;
      fill_q     <= '0;
      wincnt_q   <= '0;
      tcnt_q     <= '0;
      trail_q    <= '0;
      peak_q     <= '0;
      terr_q     <= 1'b0;
      st_pulse_q <= 1'b0;
      to_pulse_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      fill_q     <= fill_d;
      wincnt_q   <= wincnt_d;
      tcnt_q     <= tcnt_d;
      trail_q    <= trail_d;
      peak_q     <= peak_d;
      terr_q     <= terr_d;
      st_pulse_q <= st_pulse_d;
      to_pulse_q <= to_pulse_d;
    end
  end

  assign rx_trailer_st_p = st_pulse_q;
  assign corr_timeout_p  = to_pulse_q;
  assign sync_lock       = (state_q == ST_LOCKED);
  assign trailer_err     = terr_q;
  assign corr_peak       = peak_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_rxaccesscorr.sv
// Directed testbench for rxaccesscorr.
module tb_rxaccesscorr;
  import rxcorr_pkg::*;

  localparam logic [63:0] W   = 64'h4E1C_3A9F_0B72_D815;
  localparam logic [63:0] ERR = 64'h0004_0000_4000_0020; // bits 5, 30, 50
  localparam logic [63:0] PFX = 64'h0000_0000_000A_5C3B; // 20 prefix bits

  // ---------------- clock / reset ----------------
  logic        clk_6M = 1'b0;
  logic        rstz;
  logic        p_1us;
  logic        rxbit;
  logic        corr_en;
  logic [63:0] regi_syncword;
  logic [6:0]  regi_corrthr;
  logic [11:0] regi_searchwin;
  logic        rx_trailer_st_p;
  logic        sync_lock;
  logic        trailer_err;
  logic        corr_timeout_p;
  logic [6:0]  corr_peak;
  logic [2:0]  dbg_state;

  always #83 clk_6M = ~clk_6M;

  rxaccesscorr #(.SYNCLEN(64), .TRAILLEN(4), .WINW(12)) dut (
    .clk_6M          (clk_6M),
    .rstz            (rstz),
    .p_1us           (p_1us),
    .rxbit           (rxbit),
    .corr_en         (corr_en),
    .regi_syncword   (regi_syncword),
    .regi_corrthr    (regi_corrthr),
    .regi_searchwin  (regi_searchwin),
    .rx_trailer_st_p (rx_trailer_st_p),
    .sync_lock       (sync_lock),
    .trailer_err     (trailer_err),
    .corr_timeout_p  (corr_timeout_p),
    .corr_peak       (corr_peak),
    .dbg_state       (dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int strobe_idx;
  int mp_cnt, to_cnt;   // pulse-high cycles seen
  int mp_at, to_at;     // strobe index whose next cycle carried the pulse

  // Counts every cycle a pulse is high, so a stretched pulse counts twice.
  always @(negedge clk_6M) begin
    if (rx_trailer_st_p === 1'b1) mp_cnt++;
    if (corr_timeout_p === 1'b1) to_cnt++;
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_6M);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input int gap);
    p_1us = 1'b1;
    rxbit = b;
    strobe_idx++;
    @(posedge clk_6M);
    #1;
    p_1us = 1'b0;
    if (rx_trailer_st_p === 1'b1) mp_at = strobe_idx;
    if (corr_timeout_p === 1'b1) to_at = strobe_idx;
    tick(gap);
  endtask

  task automatic send_bits(input logic [63:0] v, input int n, input int gap);
    for (int i = 0; i < n; i++) send_bit(v[i], gap);
  endtask

  task automatic begin_search(input logic [63:0] sw, input logic [6:0] thr,
                              input logic [11:0] win);
    regi_syncword  = sw;
    regi_corrthr   = thr;
    regi_searchwin = win;
    strobe_idx = 0;
    mp_cnt = 0;
    to_cnt = 0;
    mp_at  = -1;
    to_at  = -1;
    corr_en = 1'b1;
    tick(2);
  endtask

  task automatic end_search();
    corr_en = 1'b0;
    tick(2);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstz = 1'b1; p_1us = 1'b0; rxbit = 1'b0; corr_en = 1'b0;
    regi_syncword = W; regi_corrthr = 7'd64; regi_searchwin = 12'd100;
    tick(3);
    rstz = 1'b0;
    tick(2);
    n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); else n_pass++;
    n_checks++; if ({rx_trailer_st_p, corr_timeout_p, sync_lock, trailer_err} !== 4'b0) $display("FAIL reset_flags: got %b want 0000", {rx_trailer_st_p, corr_timeout_p, sync_lock, trailer_err}); else n_pass++;
    n_checks++; if (corr_peak !== 7'd0) $display("FAIL reset_peak: got %0d want 0", corr_peak); else n_pass++;
  endtask

  task automatic test_exact_match();
    begin_search(W, 7'd64, 12'd4095);
    send_bits(PFX, 20, 2);
    send_bits(W, 64, 2);
    n_checks++; if (mp_at !== 84) $display("FAIL exact_match_at: got %0d want 84", mp_at); else n_pass++;
    n_checks++; if (corr_peak !== 7'd64) $display("FAIL exact_peak: got %0d want 64", corr_peak); else n_pass++;
    n_checks++; if (dbg_state !== ST_TRAILER) $display("FAIL exact_trailer_state: got %0d want %0d", dbg_state, ST_TRAILER); else n_pass++;
    send_bits(64'b0101, 3, 2);       // receive order 1,0,1
    send_bit(1'b0, 0);               // 4th trailer bit
    n_checks++; if (sync_lock !== 1'b1) $display("FAIL exact_lock: got %b want 1", sync_lock); else n_pass++;
    n_checks++; if (trailer_err !== 1'b0) $display("FAIL exact_terr: got %b want 0", trailer_err); else n_pass++;
    tick(2);
    n_checks++; if (mp_cnt !== 1 || to_cnt !== 0) $display("FAIL exact_pulse_cnt: got match %0d timeout %0d want 1 0", mp_cnt, to_cnt); else n_pass++;
    end_search();
    n_checks++; if (dbg_state !== ST_IDLE || sync_lock !== 1'b0) $display("FAIL exact_unlock: got state %0d lock %b want %0d 0", dbg_state, sync_lock, ST_IDLE); else n_pass++;
  endtask

  task automatic test_bit_errors();
    begin_search(W, 7'd61, 12'd4095);
    send_bits(PFX, 20, 2);
    send_bits(W ^ ERR, 64, 2);
    n_checks++; if (mp_at !== 84) $display("FAIL err61_match_at: got %0d want 84", mp_at); else n_pass++;
    n_checks++; if (corr_peak !== 7'd61) $display("FAIL err61_peak: got %0d want 61", corr_peak); else n_pass++;
    send_bits(64'b0101, 4, 2);
    n_checks++; if (sync_lock !== 1'b1 || trailer_err !== 1'b0) $display("FAIL err61_lock: got lock %b err %b want 1 0", sync_lock, trailer_err); else n_pass++;
    end_search();

    begin_search(W, 7'd62, 12'd200);
    send_bits(PFX, 20, 2);
    send_bits(W ^ ERR, 64, 2);
    send_bits(64'd0, 64, 2);
    send_bits(64'd0, 52, 2);         // 200 strobes in total
    n_checks++; if (to_at !== 200) $display("FAIL err62_timeout_at: got %0d want 200", to_at); else n_pass++;
    n_checks++; if (mp_cnt !== 0 || to_cnt !== 1) $display("FAIL err62_pulse_cnt: got match %0d timeout %0d want 0 1", mp_cnt, to_cnt); else n_pass++;
    n_checks++; if (corr_peak !== 7'd61) $display("FAIL err62_peak: got %0d want 61", corr_peak); else n_pass++;
    n_checks++; if (dbg_state !== ST_WAITOFF) $display("FAIL err62_state: got %0d want %0d", dbg_state, ST_WAITOFF); else n_pass++;
    end_search();
  endtask

  task automatic test_bad_trailer();
    begin_search(W, 7'd64, 12'd4095);
    send_bits(PFX, 20, 2);
    send_bits(W, 64, 2);
    n_checks++; if (mp_at !== 84) $display("FAIL badtr_match_at: got %0d want 84", mp_at); else n_pass++;
    send_bits(64'b0000, 4, 2);
    n_checks++; if (sync_lock !== 1'b1 || trailer_err !== 1'b1) $display("FAIL badtr_flags: got lock %b err %b want 1 1", sync_lock, trailer_err); else n_pass++;
    end_search();
  endtask

  task automatic test_back_to_back();
    // All-zero sync word: every partial window already agrees, so only the
    // fill gate keeps a match off until the 64th strobe.
    begin_search(64'd0, 7'd64, 12'd4095);
    send_bits(64'd0, 63, 0);
    n_checks++; if (mp_at !== -1) $display("FAIL fill_early_match: got %0d want -1", mp_at); else n_pass++;
    send_bit(1'b0, 0);
    n_checks++; if (mp_at !== 64) $display("FAIL fill_match_at: got %0d want 64", mp_at); else n_pass++;
    send_bits(64'b0101, 4, 0);
    n_checks++; if (sync_lock !== 1'b1 || trailer_err !== 1'b0) $display("FAIL b2b_lock: got lock %b err %b want 1 0", sync_lock, trailer_err); else n_pass++;
    tick(2);
    n_checks++; if (mp_cnt !== 1) $display("FAIL b2b_pulse_width: got %0d cycles want 1", mp_cnt); else n_pass++;
    end_search();

    // Threshold 0 with a syncword[63]=1 word: match at fill, inverted trailer.
    begin_search(~W, 7'd0, 12'd4095);
    send_bits(W, 64, 1);
    n_checks++; if (mp_at !== 64) $display("FAIL thr0_match_at: got %0d want 64", mp_at); else n_pass++;
    send_bits(64'b1010, 4, 1);       // receive order 0,1,0,1
    n_checks++; if (sync_lock !== 1'b1 || trailer_err !== 1'b0) $display("FAIL alt_trailer: got lock %b err %b want 1 0", sync_lock, trailer_err); else n_pass++;
    end_search();
  endtask

  task automatic test_abort_and_reset();
    begin_search(W, 7'd64, 12'd4095);
    send_bits(PFX, 20, 2);
    send_bits(W, 10, 2);
    corr_en = 1'b0;
    tick(1);
    n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL abort_state: got %0d want %0d", dbg_state, ST_IDLE); else n_pass++;
    tick(2);
    n_checks++; if (mp_cnt !== 0 || to_cnt !== 0 || sync_lock !== 1'b0) $display("FAIL abort_outputs: got match %0d timeout %0d lock %b want 0 0 0", mp_cnt, to_cnt, sync_lock); else n_pass++;

    begin_search(W, 7'd64, 12'd4095);
    send_bits(PFX, 20, 2);
    send_bits(W, 64, 2);
    send_bits(64'b01, 2, 0);
    #40;
    rstz = 1'b1;                     // asynchronous, mid-cycle
    #1;
    n_checks++; if (dbg_state !== ST_IDLE || corr_peak !== 7'd0) $display("FAIL rst_async: got state %0d peak %0d want %0d 0", dbg_state, corr_peak, ST_IDLE); else n_pass++;
    corr_en = 1'b0;
    tick(3);
    rstz = 1'b0;
    tick(3);
    n_checks++; if (mp_cnt !== 1 || to_cnt !== 0 || sync_lock !== 1'b0 || trailer_err !== 1'b0) $display("FAIL rst_outputs: got match %0d timeout %0d lock %b err %b want 1 0 0 0", mp_cnt, to_cnt, sync_lock, trailer_err); else n_pass++;

    begin_search(W, 7'd64, 12'd4095);
    send_bits(PFX, 20, 2);
    send_bits(W, 64, 2);
    send_bits(64'b0101, 4, 2);
    n_checks++; if (mp_at !== 84 || sync_lock !== 1'b1) $display("FAIL relock: got match_at %0d lock %b want 84 1", mp_at, sync_lock); else n_pass++;
    end_search();
  endtask

  task automatic test_window_edges();
    begin_search(W, 7'd64, 12'd0);
    send_bit(1'b1, 2);
    n_checks++; if (to_at !== 1 || to_cnt !== 1) $display("FAIL win0_timeout: got at %0d cnt %0d want 1 1", to_at, to_cnt); else n_pass++;
    n_checks++; if (dbg_state !== ST_WAITOFF) $display("FAIL win0_state: got %0d want %0d", dbg_state, ST_WAITOFF); else n_pass++;
    send_bits(W, 10, 1);
    n_checks++; if (to_cnt !== 1 || mp_cnt !== 0 || dbg_state !== ST_WAITOFF) $display("FAIL win0_hold: got timeout %0d match %0d state %0d want 1 0 %0d", to_cnt, mp_cnt, dbg_state, ST_WAITOFF); else n_pass++;
    corr_en = 1'b0;
    tick(1);
    n_checks++; if (dbg_state !== ST_IDLE) $display("FAIL win0_release: got %0d want %0d", dbg_state, ST_IDLE); else n_pass++;
    corr_en = 1'b1;
    tick(1);
    n_checks++; if (dbg_state !== ST_SEARCH) $display("FAIL win0_rearm: got %0d want %0d", dbg_state, ST_SEARCH); else n_pass++;
    end_search();

    // Match and window expiry on the same strobe: match wins.
    begin_search(W, 7'd0, 12'd64);
    send_bits(W, 64, 2);
    n_checks++; if (mp_at !== 64 || to_cnt !== 0) $display("FAIL priority: got match_at %0d timeout %0d want 64 0", mp_at, to_cnt); else n_pass++;
    end_search();

    // Threshold above 64 never matches, even on the exact word.
    begin_search(W, 7'd65, 12'd100);
    send_bits(PFX, 20, 2);
    send_bits(W, 64, 2);
    send_bits(64'd0, 16, 2);
    n_checks++; if (mp_cnt !== 0 || to_at !== 100) $display("FAIL thr65: got match %0d timeout_at %0d want 0 100", mp_cnt, to_at); else n_pass++;
    end_search();
  endtask

  initial begin
    test_reset();
    test_exact_match();
    test_bit_errors();
    test_bad_trailer();
    test_back_to_back();
    test_abort_and_reset();
    test_window_edges();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rxaccesscorr.md
# rxaccesscorr

Receive access-code correlator. Samples the demodulated `rxbit` stream on the 1 µs strobe, slides a 64-bit window against the programmed sync word, and fires `rx_trailer_st_p` when the Hamming match reaches threshold. The match time is the receive timing anchor consumed by the header/payload receive chain. It also checks the 4-bit trailer, reports sync lock, and times out if no match arrives inside the search window.

## Interface
Parameters:
- `SYNCLEN`, 64: sync word length in bits.
- `TRAILLEN`, 4: trailer length in bits.
- `WINW`, 12: width of the search-window counter.

Ports:
- `clk_6M`  in  1  system clock, 6 MHz.
- `rstz`  in  1  reset, asynchronous, active-high.
- `p_1us`  in  1  one-cycle bit strobe; `rxbit` is valid in this cycle.
- `rxbit`  in  1  demodulated receive bit, sent LSB-first over the air.
- `corr_en`  in  1  search enable, level; opens the search window.
- `regi_syncword`  in  64  expected sync word; bit 0 is received first.
- `regi_corrthr`  in  7  match threshold, 0..64.
- `regi_searchwin`  in  WINW  search window length in µs.
- `rx_trailer_st_p`  out  1  one-cycle pulse at sync match (start of trailer).
- `sync_lock`  out  1  level: match found and trailer complete.
- `trailer_err`  out  1  level: received trailer did not match the expected pattern.
- `corr_timeout_p`  out  1  one-cycle pulse when the window expires.
- `corr_peak`  out  7  best match count since the search started.

## Operation
- `sreg[63:0]` shifts right on `p_1us`: `sreg <= {rxbit, sreg[63:1]}`. After 64 bits, `sreg[0]` holds the first bit received.
- `fill` counts shifted bits in SEARCH and saturates at 64. A match is legal only when the next value of `fill` equals 64.
- Match count: `mcnt = 64 - popcount(sreg_next ^ regi_syncword)`, 7 bits wide. It is computed on `sreg_next` so there is no extra latency.
- FSM states: IDLE, SEARCH, TRAILER, LOCKED, WAITOFF.
  - IDLE: on `corr_en` high, go to SEARCH. On entry, clear `fill`, `wincnt`, `corr_peak` and `trailer_err`.
  - SEARCH: on each `p_1us`, shift `sreg`, increment `wincnt`, and set `corr_peak <= max(corr_peak, mcnt)`.
    - If `fill` = 64 and `mcnt >= regi_corrthr`: pulse `rx_trailer_st_p`, clear `tcnt`, go to TRAILER.
    - Otherwise, if `wincnt` reaches `regi_searchwin`: pulse `corr_timeout_p`, go to WAITOFF.
    - Match has priority over timeout when both occur on the same strobe.
  - TRAILER: capture 4 bits on `p_1us`. Expected trailer is `1010` when `regi_syncword[63]` = 0, else `0101` (first-received bit listed first). After the 4th bit, set `trailer_err` on any mismatch and go to LOCKED.
  - LOCKED: `sync_lock` = 1. Go to IDLE when `corr_en` falls.
  - WAITOFF: wait for `corr_en` low, then go to IDLE. A new search needs a fresh rising level.
- `corr_en` low in SEARCH or TRAILER aborts immediately to IDLE and produces no pulse.
- `regi_corrthr` = 0 matches as soon as `fill` reaches 64. Values above 64 never match, so the search ends by timeout.
- `regi_searchwin` = 0 times out on the first strobe, unless that strobe also matches.

## Timing
- Reset values: all outputs 0, state IDLE, `sreg` 0, all counters 0.
- `rx_trailer_st_p` is registered. It is high in the `clk_6M` cycle immediately after the `p_1us` cycle that sampled the last sync bit (latency 1).
- `corr_timeout_p` has the same latency of 1 cycle.
- `sync_lock` and `trailer_err` rise 1 cycle after the `p_1us` that sampled the 4th trailer bit.
- `corr_peak` updates 1 cycle after each SEARCH strobe.
- Reset asserted mid-search or in LOCKED clears everything asynchronously. No pulse is emitted during or after reset.
- Pulses are never longer than 1 cycle, including when `p_1us` is high on consecutive cycles.

## Structure
- Shared package `rxcorr_pkg` holds the state encoding, `SYNCLEN`, `TRAILLEN`, and the two trailer constants.
- One sub-module, `popcount64`: combinational 64-bit population count with a 7-bit output, built as an adder tree.

## Test plan
- Sync word `0x4E1C_3A9F_0B72_D815`, threshold 64, error-free stream after 20 random bits -> exactly one `rx_trailer_st_p` 1 cycle after the 64th sync bit; trailer correct -> `sync_lock` = 1, `trailer_err` = 0.
- Same word with 3 bit errors: threshold 61 -> match with `corr_peak` = 61; threshold 62 -> no match, then `corr_timeout_p` at window = 200 µs, `corr_peak` = 61.
- Exact sync word with a corrupted trailer (`0000`) -> `rx_trailer_st_p` fires, then `sync_lock` = 1 and `trailer_err` = 1.
- Sync word present in the first 63 bits only (`fill` < 64) -> no match; the first legal match comes on the 64th strobe.
- `corr_en` dropped mid-SEARCH, and separately `rstz` pulsed mid-TRAILER -> no pulses, state IDLE, outputs 0; a re-enabled search locks normally.
- Window = 0 -> `corr_timeout_p` on the first strobe; `corr_en` held high -> stays in WAITOFF with no second pulse until `corr_en` toggles.
